// File: rtl/mux4_by2_pkg.sv
// Shared select encoding for the registered 4:1 multiplexer.
// Each encoding names the data input it routes to Y.
package mux4_by2_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    localparam int unsigned WIDTH_MIN = 32'd1;
    localparam int unsigned WIDTH_MAX = 32'd64;

endpackage : mux4_by2_pkg

// File: rtl/mux4_by2_mux2.sv
// Purely combinational 2:1 multiplexer; the leaf cell of the mux4_by2 select tree.
// The whole word follows one select bit.
module mux2
    import mux4_by2_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // Route b when s is set, otherwise a.
    always_comb begin
        y = a;
        if (s) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule : mux2

// File: rtl/mux4_by2.sv
// Registered 4:1 multiplexer built from three 2:1 cells: S[0] picks within each
// pair, S[1] picks between the pairs, and one register stage drives Y.
module mux4_by2
    import mux4_by2_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] Y,
    output logic             out_valid
);

    sel_t             sel_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] y_r;
    logic             valid_r;

    assign sel_s = S;

    mux2 #(.WIDTH(WIDTH)) u_mux_lo (
        .a (A),
        .b (B),
        .s (sel_s[0]),
        .y (lo_s)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux_hi (
        .a (C),
        .b (D),
        .s (sel_s[0]),
        .y (hi_s)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux_out (
        .a (lo_s),
        .b (hi_s),
        .s (sel_s[1]),
        .y (mux_s)
    );

    // Output stage: reset wins, a valid cycle captures the tree, an idle cycle holds data.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r     <= '0;
            valid_r <= 1'b0;
        end else if (in_valid) begin
            y_r     <= mux_s;
            valid_r <= 1'b1;
        end else begin
            y_r     <= y_r;
            valid_r <= 1'b0;
        end
    end

    assign Y         = y_r;
    assign out_valid = valid_r;

endmodule : mux4_by2

// File: tb/tb_mux4_by2.sv
// Directed bench for mux4_by2: an 8-bit and a 1-bit instance share control; the
// 1-bit instance sees bit 0 of the same data, so its expectation is bit 0 of Y.
module tb_mux4_by2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] s;
    logic [7:0] a, b, c, d;
    logic [7:0] y8;
    logic       v8;
    logic [0:0] y1;
    logic       v1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       in_valid;
        logic [1:0] s;
        logic [7:0] a, b, c, d;
        logic [7:0] exp_y;
        logic       exp_v;
    } vec_t;

    vec_t vecs[$];

    mux4_by2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a), .B(b), .C(c), .D(d), .S(s),
        .Y(y8), .out_valid(v8)
    );

    mux4_by2 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]), .S(s),
        .Y(y1), .out_valid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic iv, input logic [1:0] sv,
                                input logic [7:0] av, bv, cv, dv,
                                input logic [7:0] ey, input logic ev);
        vec_t t;
        t.rst = r; t.in_valid = iv; t.s = sv;
        t.a = av; t.b = bv; t.c = cv; t.d = dv;
        t.exp_y = ey; t.exp_v = ev;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ey, input logic ev);
        check({tag, " Y8"}, {56'd0, y8}, {56'd0, ey});
        check({tag, " valid8"}, {63'd0, v8}, {63'd0, ev});
        check({tag, " Y1"}, {63'd0, y1}, {63'd0, ey[0]});
        check({tag, " valid1"}, {63'd0, v1}, {63'd0, ev});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; in_valid = t.in_valid; s = t.s;
        a = t.a; b = t.b; c = t.c; d = t.d;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; s = 2'b00;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;

        // Reset held for two edges with arbitrary inputs and in_valid high.
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1; in_valid = 1'b1;
            s = 2'($urandom_range(3, 0));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            a[0] = 1'b1; b[0] = 1'b1; c[0] = 1'b1; d[0] = 1'b1;
            step();
            check_all($sformatf("reset%0d", i), 8'h00, 1'b0);
        end

        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0));
        // One-hot walk.
        vecs.push_back(mk(1'b0, 1'b1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1));
        // Isolation: only A, then only B, C, D set, with S stepping through all codes.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                vecs.push_back(mk(1'b0, 1'b1, 2'(j),
                                  (k == 0) ? 8'h01 : 8'h00, (k == 1) ? 8'h01 : 8'h00,
                                  (k == 2) ? 8'h01 : 8'h00, (k == 3) ? 8'h01 : 8'h00,
                                  (j == k) ? 8'h01 : 8'h00, 1'b1));
            end
        end
        // Wide data with S changing every cycle.
        vecs.push_back(mk(1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 1'b1));
        // Hold: capture A5, then idle cycles with changing select and data.
        vecs.push_back(mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h02, 8'hA5, 8'h03, 8'hA5, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 8'hFF, 8'h0E, 8'h5C, 8'h3D, 8'hA5, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 8'h10, 8'h20, 8'h30, 8'h77, 8'hA5, 1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_v);
        end

        // Y must not follow inputs between edges.
        rst = 1'b0; in_valid = 1'b1; s = 2'b01;
        a = 8'h00; b = 8'h3C; c = 8'h00; d = 8'h00;
        step();
        check_all("capture3C", 8'h3C, 1'b1);
        b = 8'hC3; s = 2'b10; c = 8'hFF;
        #3;
        check_all("midcycle", 8'h3C, 1'b1);

        // Reset on the same edge as a valid D select discards the value.
        rst = 1'b1; in_valid = 1'b1; s = 2'b11; d = 8'h99;
        step();
        check_all("rst_midstream", 8'h00, 1'b0);
        rst = 1'b0; in_valid = 1'b0; d = 8'h5A;
        step();
        check_all("post_rst_idle", 8'h00, 1'b0);
        in_valid = 1'b1; s = 2'b11; d = 8'h5A;
        step();
        check_all("post_rst_valid", 8'h5A, 1'b1);
        in_valid = 1'b0;
        step();
        check_all("post_rst_hold", 8'h5A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux4_by2

// File: doc/mux4_by2.md
Name: mux4_by2

Overview:
- 4:1 multiplexer built as a tree of three 2:1 multiplexers, with a registered output stage.
- Selects one of four equal-width data inputs (A, B, C, D) using a 2-bit select S.
- Sits in the datapath wherever a registered 4-way source select is needed.
- Combinational tree, then one output register clocked by clk.

Parameters:
- WIDTH, default 1: bit width of each data input and of Y; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  marks A/B/C/D/S as meaningful this cycle
- A  input  WIDTH  data input, selected when S=2'b00
- B  input  WIDTH  data input, selected when S=2'b01
- C  input  WIDTH  data input, selected when S=2'b10
- D  input  WIDTH  data input, selected when S=2'b11
- S  input  2  select; S[0] drives the first level, S[1] the second level
- Y  output  WIDTH  registered selected data
- out_valid  output  1  Y holds a result captured from a cycle with in_valid=1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Tree structure:
  - lo = S[0] ? B : A
  - hi = S[0] ? D : C
  - sel = S[1] ? hi : lo
- Truth table: 00→A, 01→B, 10→C, 11→D. All WIDTH bits use the same select; there is no per-bit selection.
- Reset: on a rising clk edge with rst=1, Y <= 0 and out_valid <= 0. Reset has priority over in_valid.
- Reset asserted mid-stream discards the in-flight value. The first valid output after reset needs a fresh in_valid cycle.
- Latency: exactly 1 clock.
  - At each rising edge with rst=0 and in_valid=1: Y <= sel and out_valid <= 1.
  - At each rising edge with rst=0 and in_valid=0: Y holds its previous value and out_valid <= 0.
- Y never changes between clock edges; there is no combinational path from inputs to Y.
- Back-to-back: a new select and new data every cycle are supported at full throughput, with no bubbles.
- Data and select changing in the same cycle: the value sampled at the edge is the one used.
- There is no arithmetic and no width extension: Y width equals WIDTH exactly.

Decomposition:
- Shared package mux4_by2_pkg holds:
  - select constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11
  - typedef sel_t as logic [1:0]
- Sub-module mux2 (parameter WIDTH):
  - ports a, b, s, y; y = s ? b : a; purely combinational
  - instantiated three times: two at the first level, one at the second
- The top level adds only the output register and the valid register.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs → Y=0 and out_valid=0 after each edge. Deassert rst → Y stays 0 until a cycle with in_valid=1.
- One-hot walk, WIDTH=1, in_valid=1, one setting per cycle:
  - A=1, B=0, C=0, D=0, S=00 → Y=1 one cycle later
  - A=0, B=1, C=0, D=0, S=01 → Y=1
  - A=0, B=0, C=1, D=0, S=10 → Y=1
  - A=0, B=0, C=0, D=1, S=11 → Y=1
  - out_valid=1 throughout.
- Isolation: A=1, B=0, C=0, D=0 held while S steps 00, 01, 10, 11 → Y=1, 0, 0, 0, each lagging S by 1 cycle. Repeat with each input being the only 1.
- Wide data, WIDTH=8: A=8'h11, B=8'h22, C=8'h33, D=8'h44, with S changing every cycle 11, 00, 10, 01 → Y=44, 11, 33, 22 on consecutive cycles.
- Hold and valid: in_valid=1 with S=10 and C=8'hA5 → Y=A5. Then in_valid=0 while S and the data change → Y stays A5 and out_valid=0.
- Reset mid-stream: rst=1 on the same edge as in_valid=1 and S=11 → Y=0 and out_valid=0. On the next valid cycle, D=8'h5A → Y=5A.
